// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants used by the register file and its bus.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: write port, two operand read ports and a debug read port.
interface reg_file_if
  import riscv_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [N-1:0]      wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [N-1:0]      rd1;
  logic [N-1:0]      rd2;
  logic [ADDR_W-1:0] dbg_a;
  logic [N-1:0]      dbg_d;

  modport master (
    output we, wa, wd, ra1, ra2, dbg_a,
    input  rd1, rd2, dbg_d
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_a,
    output rd1, rd2, dbg_d
  );

endinterface

// File: rtl/Mux2x1.sv
// Generic two-input multiplexer; i_sel=1 selects i_d1.
module Mux2x1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic         i_sel,
  output logic [N-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports with optional
// write-through bypass, one synchronous write port, and an unbypassed debug port.
module reg_file
  import riscv_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     rst,
  reg_file_if.slave bus
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [N-1:0] r_regs [DEPTH];

  logic         w_wr_live;
  logic         w_hit1;
  logic         w_hit2;
  logic [N-1:0] w_st1;
  logic [N-1:0] w_st2;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;

  // Reset outranks any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.we && (bus.wa != '0)) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  // A write only counts as in flight when it will actually land at the edge.
  assign w_wr_live = !rst && bus.we && (bus.wa != '0);
  assign w_hit1    = BYPASS_EN && w_wr_live && (bus.ra1 == bus.wa);
  assign w_hit2    = BYPASS_EN && w_wr_live && (bus.ra2 == bus.wa);

  assign w_st1 = (bus.ra1 == '0) ? '0 : r_regs[bus.ra1];
  assign w_st2 = (bus.ra2 == '0) ? '0 : r_regs[bus.ra2];

  Mux2x1 #(.N(N)) u_mux_rd1 (
    .i_d0  (w_st1),
    .i_d1  (bus.wd),
    .i_sel (w_hit1),
    .o_y   (w_rd1)
  );

  Mux2x1 #(.N(N)) u_mux_rd2 (
    .i_d0  (w_st2),
    .i_d1  (bus.wd),
    .i_sel (w_hit2),
    .o_y   (w_rd2)
  );

  assign bus.rd1   = w_rd1;
  assign bus.rd2   = w_rd2;
  assign bus.dbg_d = (bus.dbg_a == '0) ? '0 : r_regs[bus.dbg_a];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset sweep, and a
// randomized phase against a reference model, all checked through a scoreboard.
module tb_reg_file;

  logic clk;
  logic rst;

  reg_file_if #(.N(32), .ADDR_W(5)) bus ();

  reg_file #(.N(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl [32];
  vec_t        tbl [22];

  task automatic cmp(input string tag, input int idx, input string port,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d] %s got %h want %h", tag, idx, port, got, want);
  endtask

  task automatic check(input string tag, input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s[%0d] scoreboard empty got 0 entries want 1", tag, idx);
    end else begin
      e = sb.pop_front();
      cmp(tag, idx, "rd1",   bus.rd1,   e.rd1);
      cmp(tag, idx, "rd2",   bus.rd2,   e.rd2);
      cmp(tag, idx, "dbg_d", bus.dbg_d, e.dbg);
    end
  endtask

  // Drive one cycle of stimulus, check the pre-edge outputs, then clock it.
  task automatic apply(input vec_t v, input string tag, input int idx);
    rst       = v.rst;
    bus.we    = v.we;
    bus.wa    = v.wa;
    bus.wd    = v.wd;
    bus.ra1   = v.ra1;
    bus.ra2   = v.ra2;
    bus.dbg_a = v.dbg;
    sb.push_back('{v.e1, v.e2, v.ed});
    #1;
    check(tag, idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    exp_t e;

    //         rst   we    wa     wd            ra1    ra2    dbg    e1            e2            ed
    tbl[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'h0,        32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd0,  5'd0,  5'd3,  32'h0,        32'h0,        32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  5'd3,  32'h12345678, 32'h12345678, 32'h12345678};
    tbl[6]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[8]  = '{1'b0, 1'b1, 5'd7,  32'h00000011, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[9]  = '{1'b0, 1'b1, 5'd7,  32'hCAFEF00D, 5'd3,  5'd7,  5'd7,  32'h12345678, 32'hCAFEF00D, 32'h00000011};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[11] = '{1'b0, 1'b1, 5'd9,  32'h000000AA, 5'd9,  5'd9,  5'd9,  32'h000000AA, 32'h000000AA, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 5'd9,  32'h00000055, 5'd9,  5'd3,  5'd9,  32'h000000AA, 32'h12345678, 32'h000000AA};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd3,  5'd9,  32'h0,        32'h0,        32'h0};
    tbl[14] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 5'd0,  5'd0,  5'd1,  32'h0,        32'h0,        32'h0};
    tbl[15] = '{1'b0, 1'b1, 5'd31, 32'h80000000, 5'd1,  5'd31, 5'd1,  32'h00000001, 32'h80000000, 32'h00000001};
    tbl[16] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 5'd31, 32'h00000001, 32'h80000000, 32'h80000000};
    tbl[17] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  5'd0,  32'h80000000, 32'h00000001, 32'h0};
    tbl[18] = '{1'b0, 1'b1, 5'd4,  32'h0000000A, 5'd4,  5'd1,  5'd4,  32'h0000000A, 32'h00000001, 32'h0};
    tbl[19] = '{1'b0, 1'b1, 5'd4,  32'h0000000B, 5'd4,  5'd4,  5'd4,  32'h0000000B, 32'h0000000B, 32'h0000000A};
    tbl[20] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd4,  5'd4,  5'd4,  32'h0000000B, 32'h0000000B, 32'h0000000B};
    tbl[21] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd1,  5'd31, 32'h00000001, 32'h00000001, 32'h80000000};

    // Initial reset brings storage out of X; outputs are not checked here.
    rst = 1'b1; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.ra1 = '0; bus.ra2 = '0; bus.dbg_a = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) apply(tbl[i], "vec", i);

    // Reset clears every register: sweep all addresses on all three ports.
    v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd31, 5'd1, 32'h0000000B, 32'h80000000, 32'h00000001};
    apply(v, "sweep_rst", 0);
    for (int i = 0; i < 32; i++) begin
      v = '{1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), 32'h0, 32'h0, 32'h0};
      apply(v, "sweep", i);
    end

    // Randomized traffic over a narrow address range to force collisions.
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 300; i++) begin
      v.rst = 1'b0;
      v.we  = 1'($urandom_range(0, 1));
      v.wa  = 5'($urandom_range(0, 7));
      v.wd  = $urandom;
      v.ra1 = 5'($urandom_range(0, 7));
      v.ra2 = (i % 5 == 0) ? v.ra1 : 5'($urandom_range(0, 7));
      v.dbg = 5'($urandom_range(0, 7));
      e.rd1 = (v.ra1 == 5'd0) ? 32'h0 : mdl[v.ra1];
      e.rd2 = (v.ra2 == 5'd0) ? 32'h0 : mdl[v.ra2];
      e.dbg = (v.dbg == 5'd0) ? 32'h0 : mdl[v.dbg];
      if (v.we && v.wa != 5'd0) begin
        if (v.ra1 == v.wa) e.rd1 = v.wd;
        if (v.ra2 == v.wa) e.rd2 = v.wd;
      end
      v.e1 = e.rd1;
      v.e2 = e.rd2;
      v.ed = e.dbg;
      apply(v, "rand", i);
      if (v.we && v.wa != 5'd0) mdl[v.wa] = v.wd;
    end

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain leftover got %0d want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the single-cycle RV32I datapath: two combinational read ports and one synchronous write port.
- rd2 feeds the ALU-source 2:1 mux, which selects between rd2 and the immediate. rd1 feeds the ALU A input.
- Writes come from the write-back mux at the clock edge. x0 is hardwired to zero.
- A third read-only debug port exposes any register to benches.

Parameters:
- N, 32, data width of each register
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, when 1 a read of the address being written returns the write data in the same cycle

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  N  write data
- ra1  in  ADDR_W  read address, port 1 (rs1)
- ra2  in  ADDR_W  read address, port 2 (rs2)
- rd1  out  N  read data, port 1
- rd2  out  N  read data, port 2
- dbg_a  in  ADDR_W  debug read address
- dbg_d  out  N  debug read data; never bypassed

Behaviour:
- Reset:
  - One clock, synchronous, active-high: rst sampled high at a rising edge of clk clears all DEPTH registers to 0.
  - After that edge rd1 = rd2 = dbg_d = 0 for every address.
- rst has priority over we. A write presented in the same cycle as rst is discarded.
- While rst=1, bypass is disabled: reads return stored contents only.
- Write: at a rising edge with rst=0, we=1 and wa!=0, register[wa] <= wd.
- x0 handling:
  - Writes with wa=0 are ignored.
  - Reads of address 0 always return 0 on all three ports, including under bypass.
- Read latency:
  - Zero cycles. rd1, rd2 and dbg_d are combinational functions of their address and current contents.
  - Written data is visible on the non-bypass path from the cycle after the edge.
- Bypass (BYPASS=1):
  - If we=1, rst=0, wa!=0 and ra1==wa, then rd1=wd in the same cycle. The same rule applies to rd2 with ra2.
  - dbg_d is never bypassed.
- BYPASS=0: reads always return stored contents; new data appears after the edge.
- Simultaneous events:
  - ra1==ra2==wa: both ports obey the bypass rule identically.
  - ra1==ra2 with no write: both ports return identical data.
- No other state; no handshakes. we is a single-cycle strobe; a held we rewrites every cycle.
- Width rules: addresses are unsigned, and every address in 0..DEPTH-1 is valid, so there is no out-of-range case. Data is stored unmodified.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32, REG_ADDR_W=5, REG_COUNT=32
  - constant REG_ZERO=5'd0
- Single module, no sub-modules. The bypass selects use the existing Mux2x1 (N=XLEN), one instance per read port, with sel = bypass-hit.

Test Plan:
- Reset clear: preload x5=32'hDEADBEEF, assert rst one cycle -> rd1 with ra1=5 reads 32'h0; dbg_d for all 32 addresses reads 0.
- Basic write/read: we=1, wa=3, wd=32'h12345678, edge; then we=0, ra1=3, ra2=3 -> rd1=rd2=32'h12345678 with no added cycle.
- x0 protection: we=1, wa=0, wd=32'hFFFFFFFF, edge -> rd1 (ra1=0)=0 and dbg_d (dbg_a=0)=0. Also during the write cycle with ra1=0 -> rd1=0 (no bypass to x0).
- Bypass: x7 holds 32'h00000011; in the same cycle drive we=1, wa=7, wd=32'hCAFEF00D, ra2=7, dbg_a=7 -> before the edge rd2=32'hCAFEF00D and dbg_d=32'h00000011; after the edge dbg_d=32'hCAFEF00D.
- Reset beats write: x9 holds 32'h000000AA; rst=1, we=1, wa=9, wd=32'h55 at the same edge -> x9=0 after the edge; rd1 (ra1=9) shows 32'hAA before the edge (no bypass while rst=1).
- Dual port independence: x1=32'h1, x31=32'h80000000; ra1=1, ra2=31 -> rd1=32'h1, rd2=32'h80000000. Swap the addresses -> outputs swap in the same cycle.
